// File: rtl/shape_pkg.sv
// -----------------------------------------------------------------------------
// shape_pkg
// Shared definitions for the shape-record RAM mover: widths, record layout
// (word index of each field inside a record), the packed shape record and the
// engine state encoding. Also provides helpers that map between a record and
// its individual RAM words.
// -----------------------------------------------------------------------------
package shape_pkg;

   localparam int CORDW        = 10;  // x / y coordinate width
   localparam int ADDRW        = 20;  // RAM address width
   localparam int DATAW        = 12;  // RAM word width (ty / size / rotate / id)
   localparam int RECORD_WORDS = 8;   // address stride between records
   localparam int NUM_FIELDS   = 5;   // words actually used per record

   // Word offset of each field inside a record
   localparam logic [2:0] FIELD_TY   = 3'd0;
   localparam logic [2:0] FIELD_X    = 3'd1;
   localparam logic [2:0] FIELD_Y    = 3'd2;
   localparam logic [2:0] FIELD_SIZE = 3'd3;
   localparam logic [2:0] FIELD_ROT  = 3'd4;

   typedef struct packed {
      logic [DATAW-1:0] ty;
      logic [CORDW-1:0] x;
      logic [CORDW-1:0] y;
      logic [DATAW-1:0] size;
      logic [DATAW-1:0] rotate;
   } shape_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ      = 2'd2,
      ST_READ_TAIL = 2'd3
   } state_t;

   // RAM word k of a record; coordinates are zero-extended to the word width
   function automatic logic [DATAW-1:0] field_word(input shape_t s, input logic [2:0] k);
      logic [DATAW-1:0] w;
      case (k)
         FIELD_TY:   w = s.ty;
         FIELD_X:    w = {{(DATAW-CORDW){1'b0}}, s.x};
         FIELD_Y:    w = {{(DATAW-CORDW){1'b0}}, s.y};
         FIELD_SIZE: w = s.size;
         FIELD_ROT:  w = s.rotate;
         default:    w = {DATAW{1'b0}};
      endcase
      return w;
   endfunction

   // Record with field k replaced by RAM word w; coordinates keep the low bits
   function automatic shape_t put_field(input shape_t s, input logic [2:0] k,
                                        input logic [DATAW-1:0] w);
      shape_t r;
      r = s;
      case (k)
         FIELD_TY:   r.ty     = w;
         FIELD_X:    r.x      = w[CORDW-1:0];
         FIELD_Y:    r.y      = w[CORDW-1:0];
         FIELD_SIZE: r.size   = w;
         FIELD_ROT:  r.rotate = w;
         default:    r        = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shape_ram_io.sv
// -----------------------------------------------------------------------------
// shape_ram_io
// Moves one shape record (ty, x, y, size, rotate) between the shape table in
// frame RAM and the shape controller through a single 12-bit RAM port.
// A write copies the wr_* fields into five consecutive RAM words; a read
// fetches five words (RAM has one cycle of read latency) and presents them on
// rd_* once the whole record has arrived. One word counter and one address
// adder are shared by both engines.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rd_trigger          pulse: start a record read  (accepted only when idle)
//   wr_trigger          pulse: start a record write (wins over rd_trigger)
//   id                  record index, latched with the accepted trigger
//   ram_address_offset  table base address, latched with the accepted trigger
//   ram_address         RAM address            (registered)
//   ram_enable          RAM access strobe      (registered)
//   ram_we              RAM write enable       (registered)
//   ram_din             RAM write data         (registered)
//   ram_dout            RAM read data, valid one cycle after the access
//   busy                operation in progress  (registered)
//   rd_ty..rd_rotate    last completed read record
//   wr_ty..wr_rotate    record to write
// -----------------------------------------------------------------------------
import shape_pkg::*;

module shape_ram_io (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_trigger,
   input  logic             wr_trigger,
   input  logic [DATAW-1:0] id,
   input  logic [ADDRW-1:0] ram_address_offset,
   output logic [ADDRW-1:0] ram_address,
   output logic             ram_enable,
   output logic             ram_we,
   output logic [DATAW-1:0] ram_din,
   input  logic [DATAW-1:0] ram_dout,
   output logic             busy,
   output logic [DATAW-1:0] rd_ty,
   output logic [CORDW-1:0] rd_x,
   output logic [CORDW-1:0] rd_y,
   output logic [DATAW-1:0] rd_size,
   output logic [DATAW-1:0] rd_rotate,
   input  logic [DATAW-1:0] wr_ty,
   input  logic [CORDW-1:0] wr_x,
   input  logic [CORDW-1:0] wr_y,
   input  logic [DATAW-1:0] wr_size,
   input  logic [DATAW-1:0] wr_rotate
);

   state_t           state_r;
   logic [2:0]       cnt_r;        // index of the next word to access
   logic [ADDRW-1:0] base_r;       // latched record base address
   shape_t           wr_lat_r;     // latched write record
   shape_t           rd_shadow_r;  // read record being assembled

   shape_t           wr_in_s;
   shape_t           rd_final_s;
   logic [ADDRW-1:0] trig_base_s;
   logic [ADDRW-1:0] acc_base_s;
   logic [ADDRW-1:0] acc_addr_s;
   logic [2:0]       acc_k_s;
   logic [2:0]       cap_k_s;

   // Bundle the write inputs into a record
   always_comb begin
      wr_in_s = {wr_ty, wr_x, wr_y, wr_size, wr_rotate};
   end

   // Shared address adder: in IDLE it forms word 0 straight from the inputs so
   // the first access happens in the first busy cycle
   always_comb begin
      trig_base_s = ram_address_offset + (ADDRW'(id) * ADDRW'(RECORD_WORDS));
      if (state_r == ST_IDLE) begin
         acc_base_s = trig_base_s;
         acc_k_s    = FIELD_TY;
      end else begin
         acc_base_s = base_r;
         acc_k_s    = cnt_r;
      end
      acc_addr_s = acc_base_s + ADDRW'(acc_k_s);
      // RAM data returning now belongs to the access issued two counts ago
      cap_k_s    = cnt_r - 3'd2;
      rd_final_s = put_field(rd_shadow_r, FIELD_ROT, ram_dout);
   end

   // Engine FSM with registered RAM port, busy and read-record outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 3'd0;
         base_r      <= {ADDRW{1'b0}};
         wr_lat_r    <= '0;
         rd_shadow_r <= '0;
         busy        <= 1'b0;
         ram_enable  <= 1'b0;
         ram_we      <= 1'b0;
         ram_address <= {ADDRW{1'b0}};
         ram_din     <= {DATAW{1'b0}};
         rd_ty       <= {DATAW{1'b0}};
         rd_x        <= {CORDW{1'b0}};
         rd_y        <= {CORDW{1'b0}};
         rd_size     <= {DATAW{1'b0}};
         rd_rotate   <= {DATAW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (wr_trigger) begin
                  state_r     <= ST_WRITE;
                  base_r      <= trig_base_s;
                  wr_lat_r    <= wr_in_s;
                  cnt_r       <= 3'd1;
                  busy        <= 1'b1;
                  ram_enable  <= 1'b1;
                  ram_we      <= 1'b1;
                  ram_address <= acc_addr_s;
                  ram_din     <= field_word(wr_in_s, FIELD_TY);
               end else if (rd_trigger) begin
                  state_r     <= ST_READ;
                  base_r      <= trig_base_s;
                  cnt_r       <= 3'd1;
                  busy        <= 1'b1;
                  ram_enable  <= 1'b1;
                  ram_we      <= 1'b0;
                  ram_address <= acc_addr_s;
                  ram_din     <= {DATAW{1'b0}};
               end else begin
                  cnt_r       <= 3'd0;
                  busy        <= 1'b0;
                  ram_enable  <= 1'b0;
                  ram_we      <= 1'b0;
                  ram_address <= {ADDRW{1'b0}};
                  ram_din     <= {DATAW{1'b0}};
               end
            end
            ST_WRITE: begin
               if (cnt_r < 3'(NUM_FIELDS)) begin
                  ram_address <= acc_addr_s;
                  ram_din     <= field_word(wr_lat_r, cnt_r);
                  cnt_r       <= cnt_r + 3'd1;
               end else begin
                  state_r     <= ST_IDLE;
                  cnt_r       <= 3'd0;
                  busy        <= 1'b0;
                  ram_enable  <= 1'b0;
                  ram_we      <= 1'b0;
                  ram_address <= {ADDRW{1'b0}};
                  ram_din     <= {DATAW{1'b0}};
               end
            end
            ST_READ: begin
               if (cnt_r >= 3'd2) begin
                  rd_shadow_r <= put_field(rd_shadow_r, cap_k_s, ram_dout);
               end
               if (cnt_r < 3'(NUM_FIELDS)) begin
                  ram_address <= acc_addr_s;
                  cnt_r       <= cnt_r + 3'd1;
               end else begin
                  state_r     <= ST_READ_TAIL;
                  ram_enable  <= 1'b0;
                  ram_address <= {ADDRW{1'b0}};
               end
            end
            ST_READ_TAIL: begin
               // Last word arrives now; publish the whole record at once
               state_r   <= ST_IDLE;
               cnt_r     <= 3'd0;
               busy      <= 1'b0;
               rd_ty     <= rd_final_s.ty;
               rd_x      <= rd_final_s.x;
               rd_y      <= rd_final_s.y;
               rd_size   <= rd_final_s.size;
               rd_rotate <= rd_final_s.rotate;
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= 3'd0;
               busy        <= 1'b0;
               ram_enable  <= 1'b0;
               ram_we      <= 1'b0;
               ram_address <= {ADDRW{1'b0}};
               ram_din     <= {DATAW{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shape_ram_io.sv
// -----------------------------------------------------------------------------
// tb_shape_ram_io
// Self-checking bench for shape_ram_io. A synchronous RAM model (one cycle
// read latency) sits on the RAM port; a reference memory plus expected rd_*
// record predict every access and every read result from the record layout.
// -----------------------------------------------------------------------------
module tb_shape_ram_io;

   logic        clk;
   logic        rst;
   logic        rd_trigger;
   logic        wr_trigger;
   logic [11:0] id;
   logic [19:0] ram_address_offset;
   logic [19:0] ram_address;
   logic        ram_enable;
   logic        ram_we;
   logic [11:0] ram_din;
   logic [11:0] ram_dout;
   logic        busy;
   logic [11:0] rd_ty;
   logic [9:0]  rd_x;
   logic [9:0]  rd_y;
   logic [11:0] rd_size;
   logic [11:0] rd_rotate;
   logic [11:0] wr_ty;
   logic [9:0]  wr_x;
   logic [9:0]  wr_y;
   logic [11:0] wr_size;
   logic [11:0] wr_rotate;

   int errors = 0;
   int checks = 0;

   // reference memory and expected read record
   logic [11:0] ref_mem [int];
   logic [11:0] exp_ty, exp_size, exp_rot;
   logic [9:0]  exp_x, exp_y;

   shape_ram_io dut (
      .clk(clk), .rst(rst), .rd_trigger(rd_trigger), .wr_trigger(wr_trigger),
      .id(id), .ram_address_offset(ram_address_offset),
      .ram_address(ram_address), .ram_enable(ram_enable), .ram_we(ram_we),
      .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy),
      .rd_ty(rd_ty), .rd_x(rd_x), .rd_y(rd_y), .rd_size(rd_size),
      .rd_rotate(rd_rotate), .wr_ty(wr_ty), .wr_x(wr_x), .wr_y(wr_y),
      .wr_size(wr_size), .wr_rotate(wr_rotate)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // synchronous RAM, one cycle read latency
   logic [11:0] ram_mem [0:(1<<20)-1];
   always @(posedge clk) begin
      if (ram_enable && ram_we) ram_mem[ram_address] <= ram_din;
      if (ram_enable && !ram_we) ram_dout <= ram_mem[ram_address];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int addr_of(input int off, input int rid, input int k);
      return (off + rid * 8 + k) & 32'h000F_FFFF;
   endfunction

   function automatic logic [11:0] ref_get(input int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 12'h000;
   endfunction

   task automatic chk_rd(input string tag);
      chk({tag, " rd_ty"},     32'(rd_ty),     32'(exp_ty));
      chk({tag, " rd_x"},      32'(rd_x),      32'(exp_x));
      chk({tag, " rd_y"},      32'(rd_y),      32'(exp_y));
      chk({tag, " rd_size"},   32'(rd_size),   32'(exp_size));
      chk({tag, " rd_rotate"}, 32'(rd_rotate), 32'(exp_rot));
   endtask

   // One operation: trigger, monitor until busy falls (bounded), then check
   // busy length, every RAM access and the resulting rd_* record.
   task automatic run_op(input bit do_wr, input bit do_rd, input int rid, input int roff,
                         input logic [11:0] t, input logic [9:0] x, input logic [9:0] y,
                         input logic [11:0] s, input logic [11:0] r,
                         input int rd_pulse, input string tag);
      int          busy_cnt;
      int          a;
      logic [11:0] w;
      logic [11:0] exp_w [5];
      logic [19:0] acc_a [$];
      logic        acc_we [$];
      logic [11:0] acc_d [$];
      exp_w = '{t, {2'b00, x}, {2'b00, y}, s, r};
      @(negedge clk);
      wr_trigger = do_wr; rd_trigger = do_rd;
      id = 12'(rid); ram_address_offset = 20'(roff);
      wr_ty = t; wr_x = x; wr_y = y; wr_size = s; wr_rotate = r;
      @(negedge clk);
      // scramble inputs: the engine must work from latched values
      wr_trigger = 1'b0; rd_trigger = 1'b0;
      id = 12'($urandom); ram_address_offset = 20'($urandom);
      wr_ty = 12'($urandom); wr_x = 10'($urandom); wr_y = 10'($urandom);
      wr_size = 12'($urandom); wr_rotate = 12'($urandom);
      busy_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         if (!busy) break;
         busy_cnt++;
         if (ram_enable) begin
            acc_a.push_back(ram_address); acc_we.push_back(ram_we); acc_d.push_back(ram_din);
         end
         rd_trigger = (c == rd_pulse);
         @(negedge clk);
      end
      rd_trigger = 1'b0;
      chk({tag, " busy done"}, 32'(busy), 32'd0);
      for (int c = 0; c < 3; c++) begin
         if (ram_enable) begin
            acc_a.push_back(ram_address); acc_we.push_back(ram_we); acc_d.push_back(ram_din);
         end
         @(negedge clk);
      end
      chk({tag, " busy cycles"}, 32'(busy_cnt), do_wr ? 32'd5 : 32'd6);
      chk({tag, " access count"}, 32'(acc_a.size()), 32'd5);
      for (int k = 0; k < 5 && k < acc_a.size(); k++) begin
         chk($sformatf("%s addr%0d", tag, k), 32'(acc_a[k]), 32'(addr_of(roff, rid, k)));
         chk($sformatf("%s we%0d", tag, k), 32'(acc_we[k]), 32'(do_wr));
         if (do_wr) chk($sformatf("%s din%0d", tag, k), 32'(acc_d[k]), 32'(exp_w[k]));
      end
      // reference model update
      if (do_wr) begin
         for (int k = 0; k < 5; k++) ref_mem[addr_of(roff, rid, k)] = exp_w[k];
      end else begin
         exp_ty = ref_get(addr_of(roff, rid, 0));
         w = ref_get(addr_of(roff, rid, 1)); exp_x = w[9:0];
         w = ref_get(addr_of(roff, rid, 2)); exp_y = w[9:0];
         exp_size = ref_get(addr_of(roff, rid, 3));
         exp_rot = ref_get(addr_of(roff, rid, 4));
      end
      a = 0;
      chk_rd(tag);
   endtask

   initial begin
      int          rid, roff;
      logic [11:0] t, s, r;
      logic [9:0]  x, y;
      rst = 1'b1; rd_trigger = 1'b0; wr_trigger = 1'b0; id = 12'd0;
      ram_address_offset = 20'd0; wr_ty = 12'd0; wr_x = 10'd0; wr_y = 10'd0;
      wr_size = 12'd0; wr_rotate = 12'd0;
      exp_ty = 12'd0; exp_x = 10'd0; exp_y = 10'd0; exp_size = 12'd0; exp_rot = 12'd0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset en", 32'(ram_enable), 32'd0);
      chk("reset we", 32'(ram_we), 32'd0);
      chk("reset addr", 32'(ram_address), 32'd0);
      chk("reset din", 32'(ram_din), 32'd0);
      chk_rd("reset");
      rst = 1'b0;

      // basic write then read-back
      run_op(1'b1, 1'b0, 0, 614400, 12'd1, 10'd100, 10'd50, 12'd20, 12'd3, 0, "t1 write");
      run_op(1'b0, 1'b1, 0, 614400, 12'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0, "t2 read");
      // stride, x zero-extension, address wrap
      run_op(1'b1, 1'b0, 3, 614400, 12'd7, 10'd639, 10'd479, 12'd33, 12'd2, 0, "t3 write id3");
      run_op(1'b0, 1'b1, 3, 614400, 12'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0, "t3 read id3");
      run_op(1'b1, 1'b0, 0, 20'hFFFFE, 12'hABC, 10'h3FF, 10'h155, 12'hFFF, 12'h800, 0, "t3 wrap write");
      run_op(1'b0, 1'b1, 0, 20'hFFFFE, 12'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0, "t3 wrap read");
      // read trigger during a write is ignored
      run_op(1'b1, 1'b0, 5, 1000, 12'h111, 10'h222, 10'h133, 12'h444, 12'h555, 2, "t4 rd in write");
      // simultaneous triggers: write wins
      run_op(1'b1, 1'b1, 6, 2000, 12'h0F0, 10'h0AA, 10'h055, 12'h00F, 12'hF00, 0, "t5 both");
      run_op(1'b0, 1'b1, 6, 2000, 12'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0, "t5 readback");

      // randomized write/read-back pairs
      for (int i = 0; i < 10; i++) begin
         rid = int'($urandom_range(0, 4095));
         roff = int'($urandom & 32'h000F_FFFF);
         t = 12'($urandom); x = 10'($urandom); y = 10'($urandom);
         s = 12'($urandom); r = 12'($urandom);
         run_op(1'b1, 1'b0, rid, roff, t, x, y, s, r, 0, $sformatf("rand%0d wr", i));
         run_op(1'b0, 1'b1, rid, roff, 12'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0,
                $sformatf("rand%0d rd", i));
      end

      // reset in the middle of a read
      run_op(1'b0, 1'b1, 0, 614400, 12'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0, "t6 pre read");
      @(negedge clk);
      rd_trigger = 1'b1; id = 12'd3; ram_address_offset = 20'd614400;
      @(negedge clk);
      rd_trigger = 1'b0;          // cycle 1
      @(negedge clk);             // cycle 2
      @(negedge clk);             // cycle 3
      rst = 1'b1;
      @(negedge clk);
      chk("t6 busy", 32'(busy), 32'd0);
      chk("t6 en", 32'(ram_enable), 32'd0);
      chk("t6 we", 32'(ram_we), 32'd0);
      chk("t6 addr", 32'(ram_address), 32'd0);
      exp_ty = 12'd0; exp_x = 10'd0; exp_y = 10'd0; exp_size = 12'd0; exp_rot = 12'd0;
      chk_rd("t6 reset");
      rst = 1'b0;
      run_op(1'b0, 1'b1, 3, 614400, 12'd0, 10'd0, 10'd0, 12'd0, 12'd0, 0, "t6 post read");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
